dest_scoreboard: RTL and testbench
==================================

DEST_SCOREBOARD -- requirements
Module: dest_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 issue_valid  input  1  decode (p2) bundle is valid and advancing into EX this cycle.
REQ-003 issue_alu_regWrite  input  1  ALU slot writes a register.
REQ-004 issue_alu_rd  input  3  ALU slot destination (I[25:23]).
REQ-005 issue_mem_regWrite  input  1  MEM slot is a load.
REQ-006 issue_mem_rd  input  3  MEM slot destination (I[7:5]).
REQ-007 stall  input  1  hazard-unit bubble request: p2 is held and a bubble enters EX.
REQ-008 flush  input  1  kill the EX-stage (p3) entry and the bundle issued this cycle.
REQ-009 pending_mask  output  8  bit r = 1 while register r has an in-flight write.
REQ-010 load_use_mask  output  8  bit r = 1 while a load to r occupies EX (p3).
REQ-011 wb_alu_we / wb_alu_rd  output  1 / 3  register-file ALU write port, from WB.
REQ-012 wb_mem_we / wb_mem_rd  output  1 / 3  register-file MEM write port, from WB.
REQ-013 collision  output  1  one-cycle pulse: the bundle entering EX had both slots writing the same nonzero rd.

Function
REQ-014 The block SHALL hold three stage registers: EX (p3), MEM (p4), and WB (p5). Each register SHALL carry alu_v, alu_rd, mem_v, and mem_rd.
REQ-015 Every cycle not in reset, the stages SHALL advance: WB<=MEM, MEM<=EX. The EX stage SHALL load from the issue inputs.
REQ-016 EX SHALL load a bubble (all valids 0) when issue_valid=0, stall=1, or flush=1.
REQ-017 When flush=1, the existing EX entry SHALL be discarded, so MEM loads a bubble. MEM and WB SHALL advance unaffected.
REQ-018 When stall and flush are both 1, flush SHALL take priority. The result is equivalent to a bubble entering both EX and MEM.
REQ-019 Writes to register 0 SHALL never set a valid bit, and bit 0 of every mask SHALL be 0.
REQ-020 If both slots of one bundle write the same nonzero rd, the MEM write SHALL win. The ALU valid SHALL be cleared on entry to EX, and collision SHALL be 1 in the following cycle.
REQ-021 pending_mask SHALL be the OR over the EX, MEM, and WB stages of the decoded valid destinations, subject to REQ-031.
REQ-022 load_use_mask SHALL be the decoded EX.mem_rd when EX.mem_v=1, else 0.
REQ-023 wb_* outputs SHALL equal the WB stage fields. Latency from issue to the WB write port SHALL be exactly 3 cycles, with no stall or flush in between.
REQ-024 All outputs SHALL be registered-stage derived. No combinational path SHALL run from the issue inputs to any output.

Reset
REQ-025 While reset=1, all stage valids SHALL be cleared at the clock edge.
REQ-026 In the cycle after reset, pending_mask, load_use_mask, and collision SHALL be 0, and wb_alu_we and wb_mem_we SHALL be 0.
REQ-027 rd fields SHALL reset to 0.
REQ-028 A reset asserted mid-stream SHALL discard all in-flight entries, with no partial writeback.
REQ-029 Reset SHALL take priority over stall and flush.

Configuration
REQ-030 Macro DEST_SCOREBOARD_WB_BYPASS_EN SHALL be the single configuration switch.
REQ-031 With DEST_SCOREBOARD_WB_BYPASS_EN defined, the WB stage SHALL be excluded from pending_mask, because the register file writes before it is read. Without the macro, WB SHALL be included.
REQ-032 The macro SHALL affect only pending_mask. Stage contents and wb_* outputs SHALL be identical in both builds.

Structure
REQ-033 Shared package vliw_pkg SHALL hold REG_ADDR_W=3, NUM_REGS=8, and the stage-entry typedef {alu_v, alu_rd, mem_v, mem_rd}.
REQ-034 Sub-module sb_stage SHALL implement one stage register with synchronous reset and a bubble-load input. dest_scoreboard SHALL instantiate it three times.
REQ-035 The decode-to-one-hot helper SHALL be a package function.

Verification
REQ-036 The bench SHALL cover the scenarios in REQ-037 to REQ-041.
REQ-037 Issue ALU rd=3 at cycle 0 -> pending_mask=8'h08 for cycles 1-3 (cycles 1-2 with BYPASS_EN); wb_alu_we=1, wb_alu_rd=3 at cycle 3.
REQ-038 Issue load rd=5 -> load_use_mask=8'h20 for cycle 1 only; wb_mem_we=1, wb_mem_rd=5 at cycle 3.
REQ-039 Issue bundle ALU rd=2 and load rd=2 -> collision=1 at cycle 1; only wb_mem_we=1 at cycle 3; wb_alu_we=0.
REQ-040 Issue rd=4, then flush=1 in the next cycle together with a second issue rd=6 -> neither write reaches WB; pending_mask=0 from cycle 2.
REQ-041 Issue rd=0 in both slots -> all masks 0, collision=0, no wb_*_we; reset asserted with 3 entries in flight -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared definitions for the destination scoreboard.
//   REG_ADDR_W    : register address width (8 architectural registers)
//   NUM_REGS      : number of architectural registers
//   stage_entry_t : one pipeline-stage record {alu_v, alu_rd, mem_v, mem_rd}
//   STAGE_BUBBLE  : the empty stage record
//   rd_onehot()   : decode a (valid, rd) pair into a register mask; r0 never shows
package vliw_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic                  alu_v;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic                  mem_v;
    logic [REG_ADDR_W-1:0] mem_rd;
  } stage_entry_t;

  localparam stage_entry_t STAGE_BUBBLE = '0;

  // Register 0 is hard-wired, so a write to it never marks anything pending.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic                  v,
                                                     input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    if (v && (rd != '0)) begin
      oh[rd] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/sb_stage.sv
// One scoreboard pipeline stage register.
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears the whole record
//   bubble   : load an empty record instead of entry_in this cycle
//   entry_in : record arriving from the previous stage
//   entry_out: registered record held by this stage
module sb_stage
  import vliw_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         bubble,
  input  stage_entry_t entry_in,
  output stage_entry_t entry_out
);

  stage_entry_t entry_q;
  stage_entry_t entry_d;

  always_comb begin
    entry_d = entry_in;
    if (bubble) begin
      entry_d = STAGE_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= STAGE_BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_out = entry_q;

endmodule

// File: rtl/dest_scoreboard.sv
// Destination-register scoreboard for a two-slot (ALU + load) VLIW pipeline.
// Tracks in-flight register writes through EX (p3), MEM (p4) and WB (p5) and
// drives the register-file write ports from the WB stage.
//
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   issue_valid                    : decode bundle advances into EX this cycle
//   issue_alu_regWrite/issue_alu_rd: ALU slot write enable / destination
//   issue_mem_regWrite/issue_mem_rd: MEM slot (load) write enable / destination
//   stall                          : bubble enters EX, decode holds
//   flush                          : kill the EX entry and this cycle's issue
//   pending_mask                   : registers with an in-flight write
//   load_use_mask                  : destination of a load sitting in EX
//   wb_alu_we/wb_alu_rd            : ALU register-file write port (from WB)
//   wb_mem_we/wb_mem_rd            : MEM register-file write port (from WB)
//   collision                      : bundle now in EX had both slots on the same rd
//
// Configuration macro: DEST_SCOREBOARD_WB_BYPASS_EN
//   When defined, the WB stage is left out of pending_mask because the register
//   file writes before it is read. Nothing else changes between builds.
module dest_scoreboard
  import vliw_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_alu_regWrite,
  input  logic [REG_ADDR_W-1:0] issue_alu_rd,
  input  logic                  issue_mem_regWrite,
  input  logic [REG_ADDR_W-1:0] issue_mem_rd,
  input  logic                  stall,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [NUM_REGS-1:0]   load_use_mask,
  output logic                  wb_alu_we,
  output logic [REG_ADDR_W-1:0] wb_alu_rd,
  output logic                  wb_mem_we,
  output logic [REG_ADDR_W-1:0] wb_mem_rd,
  output logic                  collision
);

  stage_entry_t issue_entry;
  stage_entry_t ex_entry;
  stage_entry_t mem_entry;
  stage_entry_t wb_entry;

  logic alu_writes;
  logic mem_writes;
  logic same_rd;
  logic ex_bubble;
  logic collision_d;
  logic collision_q;

  // Build the record that enters EX. A same-rd bundle keeps only the load,
  // so the later (MEM) write is the one that lands.
  always_comb begin
    alu_writes  = issue_alu_regWrite && (issue_alu_rd != '0);
    mem_writes  = issue_mem_regWrite && (issue_mem_rd != '0);
    same_rd     = alu_writes && mem_writes && (issue_alu_rd == issue_mem_rd);

    issue_entry        = STAGE_BUBBLE;
    issue_entry.alu_v  = alu_writes && !same_rd;
    issue_entry.alu_rd = issue_alu_rd;
    issue_entry.mem_v  = mem_writes;
    issue_entry.mem_rd = issue_mem_rd;

    // Flush overrides stall; both put a bubble into EX.
    ex_bubble   = !issue_valid || stall || flush;
    // Only a bundle that really enters EX can report a collision.
    collision_d = same_rd && !ex_bubble;
  end

  // EX (p3)
  sb_stage u_ex_stage (
    .clk      (clk),
    .reset    (reset),
    .bubble   (ex_bubble),
    .entry_in (issue_entry),
    .entry_out(ex_entry)
  );

  // MEM (p4): a flush discards the entry currently leaving EX.
  sb_stage u_mem_stage (
    .clk      (clk),
    .reset    (reset),
    .bubble   (flush),
    .entry_in (ex_entry),
    .entry_out(mem_entry)
  );

  // WB (p5)
  sb_stage u_wb_stage (
    .clk      (clk),
    .reset    (reset),
    .bubble   (1'b0),
    .entry_in (mem_entry),
    .entry_out(wb_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
    end
  end

  // Outputs are decoded from stage registers only.
  always_comb begin
    pending_mask = rd_onehot(ex_entry.alu_v,  ex_entry.alu_rd)
                 | rd_onehot(ex_entry.mem_v,  ex_entry.mem_rd)
                 | rd_onehot(mem_entry.alu_v, mem_entry.alu_rd)
                 | rd_onehot(mem_entry.mem_v, mem_entry.mem_rd);
`ifndef DEST_SCOREBOARD_WB_BYPASS_EN
    pending_mask = pending_mask
                 | rd_onehot(wb_entry.alu_v, wb_entry.alu_rd)
                 | rd_onehot(wb_entry.mem_v, wb_entry.mem_rd);
`endif
    load_use_mask = rd_onehot(ex_entry.mem_v, ex_entry.mem_rd);
  end

  assign wb_alu_we = wb_entry.alu_v;
  assign wb_alu_rd = wb_entry.alu_rd;
  assign wb_mem_we = wb_entry.mem_v;
  assign wb_mem_rd = wb_entry.mem_rd;
  assign collision = collision_q;

endmodule

// File: tb/tb_dest_scoreboard.sv
`timescale 1ns/1ps
module tb_dest_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic       issue_alu_regWrite;
  logic [2:0] issue_alu_rd;
  logic       issue_mem_regWrite;
  logic [2:0] issue_mem_rd;
  logic       stall;
  logic       flush;
  logic [7:0] pending_mask;
  logic [7:0] load_use_mask;
  logic       wb_alu_we;
  logic [2:0] wb_alu_rd;
  logic       wb_mem_we;
  logic [2:0] wb_mem_rd;
  logic       collision;

  always #5 clk = ~clk;

  dest_scoreboard dut (
    .clk               (clk),
    .reset             (reset),
    .issue_valid       (issue_valid),
    .issue_alu_regWrite(issue_alu_regWrite),
    .issue_alu_rd      (issue_alu_rd),
    .issue_mem_regWrite(issue_mem_regWrite),
    .issue_mem_rd      (issue_mem_rd),
    .stall             (stall),
    .flush             (flush),
    .pending_mask      (pending_mask),
    .load_use_mask     (load_use_mask),
    .wb_alu_we         (wb_alu_we),
    .wb_alu_rd         (wb_alu_rd),
    .wb_mem_we         (wb_mem_we),
    .wb_mem_rd         (wb_mem_rd),
    .collision         (collision)
  );

  // Reference model: a history of what entered EX on each clock edge.
  // After edge n the bundle from edge n is in EX, n-1 in MEM, n-2 in WB.
  // A flush or reset marks the affected history entries as dead.
  typedef struct {
    bit       alu_v;
    bit [2:0] alu_rd;
    bit       mem_v;
    bit [2:0] mem_rd;
    bit       coll;
    bit       alive;
  } ment_t;

  localparam int HIST = 8192;
  ment_t ent [HIST];
  int    n = 2;

  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin : model
    ment_t e;
    bit    aw;
    bit    mw;
    e = '{default: 0};
    if (reset) begin
      ent[n].alive   = 1'b0;
      ent[n-1].alive = 1'b0;
    end else if (flush) begin
      ent[n].alive = 1'b0;
    end else if (issue_valid && !stall) begin
      aw       = issue_alu_regWrite && (issue_alu_rd != 3'd0);
      mw       = issue_mem_regWrite && (issue_mem_rd != 3'd0);
      e.coll   = aw && mw && (issue_alu_rd == issue_mem_rd);
      e.alu_v  = aw && !e.coll;
      e.alu_rd = issue_alu_rd;
      e.mem_v  = mw;
      e.mem_rd = issue_mem_rd;
      e.alive  = 1'b1;
    end
    if (n < HIST - 1) n = n + 1;
    ent[n] = e;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next cycle and compare every output against the model.
  task automatic tick();
    ment_t      ex;
    ment_t      mem;
    ment_t      wb;
    logic [7:0] pend;
    logic [7:0] lu;
    @(negedge clk);
    ex   = ent[n];
    mem  = ent[n-1];
    wb   = ent[n-2];
    pend = 8'h00;
    lu   = 8'h00;
    if (ex.alive && ex.alu_v)   pend[ex.alu_rd]  = 1'b1;
    if (ex.alive && ex.mem_v)   pend[ex.mem_rd]  = 1'b1;
    if (mem.alive && mem.alu_v) pend[mem.alu_rd] = 1'b1;
    if (mem.alive && mem.mem_v) pend[mem.mem_rd] = 1'b1;
`ifndef DEST_SCOREBOARD_WB_BYPASS_EN
    if (wb.alive && wb.alu_v)   pend[wb.alu_rd]  = 1'b1;
    if (wb.alive && wb.mem_v)   pend[wb.mem_rd]  = 1'b1;
`endif
    if (ex.alive && ex.mem_v)   lu[ex.mem_rd]    = 1'b1;
    check("m_pending_mask", pending_mask, pend);
    check("m_load_use_mask", load_use_mask, lu);
    check("m_collision", {7'd0, collision}, {7'd0, ex.coll});
    check("m_wb_alu_we", {7'd0, wb_alu_we}, {7'd0, wb.alive && wb.alu_v});
    check("m_wb_mem_we", {7'd0, wb_mem_we}, {7'd0, wb.alive && wb.mem_v});
    if (wb.alive && wb.alu_v) check("m_wb_alu_rd", {5'd0, wb_alu_rd}, {5'd0, wb.alu_rd});
    if (wb.alive && wb.mem_v) check("m_wb_mem_rd", {5'd0, wb_mem_rd}, {5'd0, wb.mem_rd});
  endtask

  task automatic drive(input bit v, input bit aw, input bit [2:0] ard,
                       input bit mw, input bit [2:0] mrd,
                       input bit st, input bit fl, input bit rs);
    issue_valid        = v;
    issue_alu_regWrite = aw;
    issue_alu_rd       = ard;
    issue_mem_regWrite = mw;
    issue_mem_rd       = mrd;
    stall              = st;
    flush              = fl;
    reset              = rs;
  endtask

  task automatic idle();
    drive(0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pending"}, pending_mask, 8'h00);
    check({tag, "_load_use"}, load_use_mask, 8'h00);
    check({tag, "_collision"}, {7'd0, collision}, 8'h00);
    check({tag, "_wb_alu_we"}, {7'd0, wb_alu_we}, 8'h00);
    check({tag, "_wb_mem_we"}, {7'd0, wb_mem_we}, 8'h00);
    check({tag, "_wb_alu_rd"}, {5'd0, wb_alu_rd}, 8'h00);
    check({tag, "_wb_mem_rd"}, {5'd0, wb_mem_rd}, 8'h00);
  endtask

  initial begin
    bit       v, aw, mw, st, fl, rs;
    bit [2:0] ard, mrd;

    drive(1, 1, 3'd3, 1, 3'd4, 0, 0, 1);
    tick();
    tick();
    idle();
    tick();
    check_all_zero("reset");

    // ALU write to r3: pending for three cycles, written back at cycle 3
    drive(1, 1, 3'd3, 0, 3'd0, 0, 0, 0);
    tick();
    idle();
    check("alu3_c1_pending", pending_mask, 8'h08);
    tick();
    check("alu3_c2_pending", pending_mask, 8'h08);
    tick();
`ifdef DEST_SCOREBOARD_WB_BYPASS_EN
    check("alu3_c3_pending", pending_mask, 8'h00);
`else
    check("alu3_c3_pending", pending_mask, 8'h08);
`endif
    check("alu3_c3_we", {7'd0, wb_alu_we}, 8'h01);
    check("alu3_c3_rd", {5'd0, wb_alu_rd}, 8'h03);
    tick();
    check("alu3_c4_pending", pending_mask, 8'h00);

    // Load to r5: load-use visible only while in EX
    drive(1, 0, 3'd0, 1, 3'd5, 0, 0, 0);
    tick();
    idle();
    check("ld5_c1_lu", load_use_mask, 8'h20);
    tick();
    check("ld5_c2_lu", load_use_mask, 8'h00);
    tick();
    check("ld5_c3_we", {7'd0, wb_mem_we}, 8'h01);
    check("ld5_c3_rd", {5'd0, wb_mem_rd}, 8'h05);
    tick();

    // Same-rd bundle: MEM write wins, collision pulses once
    drive(1, 1, 3'd2, 1, 3'd2, 0, 0, 0);
    tick();
    idle();
    check("col_c1", {7'd0, collision}, 8'h01);
    check("col_c1_pending", pending_mask, 8'h04);
    tick();
    check("col_c2", {7'd0, collision}, 8'h00);
    tick();
    check("col_c3_mem_we", {7'd0, wb_mem_we}, 8'h01);
    check("col_c3_mem_rd", {5'd0, wb_mem_rd}, 8'h02);
    check("col_c3_alu_we", {7'd0, wb_alu_we}, 8'h00);
    tick();

    // Flush kills the EX entry and the bundle issued alongside it
    drive(1, 1, 3'd4, 0, 3'd0, 0, 0, 0);
    tick();
    check("fl_c1_pending", pending_mask, 8'h10);
    drive(1, 1, 3'd6, 0, 3'd0, 0, 1, 0);
    tick();
    idle();
    check("fl_c2_pending", pending_mask, 8'h00);
    tick();
    check("fl_c3_pending", pending_mask, 8'h00);
    check("fl_c3_we", {7'd0, wb_alu_we}, 8'h00);
    tick();
    check("fl_c4_we", {7'd0, wb_alu_we}, 8'h00);

    // Stall together with flush: nothing enters
    drive(1, 1, 3'd1, 1, 3'd7, 1, 1, 0);
    tick();
    idle();
    check("stfl_c1_pending", pending_mask, 8'h00);
    tick();
    tick();

    // Writes to r0 never count
    drive(1, 1, 3'd0, 1, 3'd0, 0, 0, 0);
    tick();
    idle();
    check("r0_c1_pending", pending_mask, 8'h00);
    check("r0_c1_lu", load_use_mask, 8'h00);
    check("r0_c1_col", {7'd0, collision}, 8'h00);
    tick();
    tick();
    check("r0_c3_alu_we", {7'd0, wb_alu_we}, 8'h00);
    check("r0_c3_mem_we", {7'd0, wb_mem_we}, 8'h00);

    // Reset with three entries in flight
    drive(1, 1, 3'd1, 0, 3'd0, 0, 0, 0);
    tick();
    drive(1, 0, 3'd0, 1, 3'd6, 0, 0, 0);
    tick();
    drive(1, 1, 3'd7, 0, 3'd0, 0, 0, 0);
    tick();
`ifdef DEST_SCOREBOARD_WB_BYPASS_EN
    check("rst3_pending", pending_mask, 8'hC0);
`else
    check("rst3_pending", pending_mask, 8'hC2);
`endif
    drive(1, 1, 3'd5, 1, 3'd5, 1, 1, 1);
    tick();
    idle();
    check_all_zero("midreset");
    tick();
    tick();
    check("midreset_c3_alu_we", {7'd0, wb_alu_we}, 8'h00);
    check("midreset_c3_mem_we", {7'd0, wb_mem_we}, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom % 4) != 0;
      aw  = $urandom % 2;
      mw  = $urandom % 2;
      ard = 3'($urandom % 8);
      mrd = (($urandom % 3) == 0) ? ard : 3'($urandom % 8);
      st  = ($urandom % 8) == 0;
      fl  = ($urandom % 10) == 0;
      rs  = ($urandom % 64) == 0;
      drive(v, aw, ard, mw, mrd, st, fl, rs);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
